calc_nport_engine: RTL and testbench

//  Parametrised N-port calculator core, successor to the fixed 4-port calc2 datapath.

---
 rtl/calc_nport_engine.sv | 199 +++++++++++++++++++
 tb/tb_calc_nport_engine.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_nport_engine.sv
// N-port calculator core: two-cycle request capture per port, per-port FIFOs, a round-robin
// arbiter and one registered ALU stage. Define CALC_SHIFT_EN to build the shl/shr shifter.
module calc_nport_engine #(
   parameter int N_PORTS = 4,
   parameter int DATA_W  = 32,
   parameter int TAG_W   = 2,
   parameter int Q_DEPTH = 4
) (
   input  logic                      c_clk,
   input  logic                      reset,
   input  logic [N_PORTS*4-1:0]      req_cmd_in,
   input  logic [N_PORTS*TAG_W-1:0]  req_tag_in,
   input  logic [N_PORTS*DATA_W-1:0] req_data_in,
   output logic [N_PORTS-1:0]        req_busy,
   output logic [N_PORTS*2-1:0]      resp_out,
   output logic [N_PORTS*TAG_W-1:0]  tag_out,
   output logic [N_PORTS*DATA_W-1:0] data_out
);

   localparam int PTR_W = $clog2(Q_DEPTH);
   localparam int CNT_W = $clog2(Q_DEPTH + 1);
   localparam int RR_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
`ifdef CALC_SHIFT_EN
   localparam int SH_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
`endif

   localparam logic [1:0] RESP_OK  = 2'b01;
   localparam logic [1:0] RESP_ERR = 2'b10;

   typedef enum logic {IDLE, OP2} portState_t;

   typedef struct packed {
      logic [3:0]        cmd;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
   } entry_t;

   portState_t        state_q  [N_PORTS];
   logic [3:0]        capCmd_q [N_PORTS];
   logic [TAG_W-1:0]  capTag_q [N_PORTS];
   logic [DATA_W-1:0] capOp1_q [N_PORTS];

   entry_t            mem_q    [N_PORTS][Q_DEPTH];
   logic [PTR_W-1:0]  wrPtr_q  [N_PORTS];
   logic [PTR_W-1:0]  rdPtr_q  [N_PORTS];
   logic [CNT_W-1:0]  count_q  [N_PORTS];
   logic [RR_W-1:0]   rrPtr_q, rrPtr_d;

   logic [N_PORTS-1:0] pushEn;
   logic [N_PORTS-1:0] popEn;
   logic               grantValid;
   logic [RR_W-1:0]    grantIdx;
   entry_t             grantEntry;
   logic [DATA_W:0]    sumFull;
   logic [1:0]         aluResp;
   logic [DATA_W-1:0]  aluData;

   logic [N_PORTS*2-1:0]      respOut_q, respOut_d;
   logic [N_PORTS*TAG_W-1:0]  tagOut_q, tagOut_d;
   logic [N_PORTS*DATA_W-1:0] dataOut_q, dataOut_d;

   // The op2 cycle always pushes; acceptance in IDLE is gated by busy, so the push always fits.
   always_comb begin
      pushEn   = '0;
      req_busy = '0;
      for (int p = 0; p < N_PORTS; p++) begin
         pushEn[p]   = (state_q[p] == OP2);
         req_busy[p] = (count_q[p] == CNT_W'(Q_DEPTH));
      end
   end

   // Round-robin search from rrPtr_q; first non-empty queue wins.
   always_comb begin
      logic [RR_W-1:0] cand;
      grantValid = 1'b0;
      grantIdx   = '0;
      cand       = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         cand = RR_W'((int'(rrPtr_q) + k) % N_PORTS);
         if (!grantValid && count_q[cand] != '0) begin
            grantValid = 1'b1;
            grantIdx   = cand;
         end
      end
      popEn   = '0;
      rrPtr_d = rrPtr_q;
      if (grantValid) begin
         popEn[grantIdx] = 1'b1;
         rrPtr_d         = RR_W'((int'(grantIdx) + 1) % N_PORTS);
      end
      grantEntry = mem_q[grantIdx][rdPtr_q[grantIdx]];
   end

   always_comb begin
      sumFull = {1'b0, grantEntry.op1} + {1'b0, grantEntry.op2};
      aluResp = RESP_ERR;
      aluData = '0;
      case (grantEntry.cmd)
         4'd1: begin
            if (!sumFull[DATA_W]) begin
               aluResp = RESP_OK;
               aluData = sumFull[DATA_W-1:0];
            end
         end
         4'd2: begin
            if (grantEntry.op2 <= grantEntry.op1) begin
               aluResp = RESP_OK;
               aluData = grantEntry.op1 - grantEntry.op2;
            end
         end
`ifdef CALC_SHIFT_EN
         4'd5: begin
            aluResp = RESP_OK;
            aluData = grantEntry.op1 << grantEntry.op2[SH_W-1:0];
         end
         4'd6: begin
            aluResp = RESP_OK;
            aluData = grantEntry.op1 >> grantEntry.op2[SH_W-1:0];
         end
`endif
         default: begin
            aluResp = RESP_ERR;
            aluData = '0;
         end
      endcase
   end

   // Only the granted port sees a response; every other lane stays all-zero.
   always_comb begin
      respOut_d = '0;
      tagOut_d  = '0;
      dataOut_d = '0;
      if (grantValid) begin
         respOut_d[int'(grantIdx)*2 +: 2]           = aluResp;
         tagOut_d[int'(grantIdx)*TAG_W +: TAG_W]    = grantEntry.tag;
         dataOut_d[int'(grantIdx)*DATA_W +: DATA_W] = aluData;
      end
   end

   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
         for (int p = 0; p < N_PORTS; p++) begin
            state_q[p]  <= IDLE;
            capCmd_q[p] <= '0;
            capTag_q[p] <= '0;
            capOp1_q[p] <= '0;
            wrPtr_q[p]  <= '0;
            rdPtr_q[p]  <= '0;
            count_q[p]  <= '0;
         end
         rrPtr_q   <= '0;
         respOut_q <= '0;
         tagOut_q  <= '0;
         dataOut_q <= '0;
      end else begin
         for (int p = 0; p < N_PORTS; p++) begin
            case (state_q[p])
               IDLE: begin
                  if (req_cmd_in[p*4 +: 4] != 4'd0 && !req_busy[p]) begin
                     capCmd_q[p] <= req_cmd_in[p*4 +: 4];
                     capTag_q[p] <= req_tag_in[p*TAG_W +: TAG_W];
                     capOp1_q[p] <= req_data_in[p*DATA_W +: DATA_W];
                     state_q[p]  <= OP2;
                  end
               end
               OP2:     state_q[p] <= IDLE;
               default: state_q[p] <= IDLE;
            endcase
            if (pushEn[p]) wrPtr_q[p] <= wrPtr_q[p] + PTR_W'(1);
            if (popEn[p])  rdPtr_q[p] <= rdPtr_q[p] + PTR_W'(1);
            case ({pushEn[p], popEn[p]})
               2'b10:   count_q[p] <= count_q[p] + CNT_W'(1);
               2'b01:   count_q[p] <= count_q[p] - CNT_W'(1);
               default: count_q[p] <= count_q[p];
            endcase
         end
         rrPtr_q   <= rrPtr_d;
         respOut_q <= respOut_d;
         tagOut_q  <= tagOut_d;
         dataOut_q <= dataOut_d;
      end
   end

   // Queue storage needs no reset: entries are only read when the count says they are valid.
   always_ff @(posedge c_clk) begin
      for (int p = 0; p < N_PORTS; p++) begin
         if (pushEn[p]) begin
            mem_q[p][wrPtr_q[p]] <= {capCmd_q[p], capTag_q[p], capOp1_q[p],
                                     req_data_in[p*DATA_W +: DATA_W]};
         end
      end
   end

   assign resp_out = respOut_q;
   assign tag_out  = tagOut_q;
   assign data_out = dataOut_q;

endmodule

// File: tb/tb_calc_nport_engine.sv
// Testbench for calc_nport_engine: directed cases plus random traffic, all checked against a
// queue-based reference model of the ports, arbiter and ALU.
`timescale 1ns/1ps
module tb_calc_nport_engine;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int TW = 2;
   localparam int QD = 4;
`ifdef CALC_SHIFT_EN
   localparam bit SHIFT_EN = 1'b1;
`else
   localparam bit SHIFT_EN = 1'b0;
`endif

   logic            c_clk = 1'b0;
   logic            reset = 1'b1;
   logic [N*4-1:0]  req_cmd_in;
   logic [N*TW-1:0] req_tag_in;
   logic [N*DW-1:0] req_data_in;
   logic [N-1:0]    req_busy;
   logic [N*2-1:0]  resp_out;
   logic [N*TW-1:0] tag_out;
   logic [N*DW-1:0] data_out;

   calc_nport_engine #(.N_PORTS(N), .DATA_W(DW), .TAG_W(TW), .Q_DEPTH(QD)) dut (
      .c_clk(c_clk), .reset(reset), .req_cmd_in(req_cmd_in), .req_tag_in(req_tag_in),
      .req_data_in(req_data_in), .req_busy(req_busy), .resp_out(resp_out),
      .tag_out(tag_out), .data_out(data_out)
   );

   always #5 c_clk = ~c_clk;

   typedef struct packed {
      logic [3:0]    cmd;
      logic [TW-1:0] tag;
      logic [DW-1:0] op1;
      logic [DW-1:0] op2;
   } req_t;

   req_t          mq [N][$];
   req_t          cap [N];
   bit            inOp2 [N];
   int            rr;
   int            dropCount [N];
   logic [1:0]    expResp [N];
   logic [TW-1:0] expTag [N];
   logic [DW-1:0] expData [N];
   int            testCount = 0;
   int            failCount = 0;

   task automatic checkOutput(input string name, input logic [63:0] observed,
                              input logic [63:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", name, observed, expected);
      end
   endtask

   function automatic void calcExpected(input req_t r, output logic [1:0] resp,
                                        output logic [DW-1:0] data);
      longint unsigned sum;
      resp = 2'b10;
      data = '0;
      case (r.cmd)
         4'd1: begin
            sum = longint'(r.op1) + longint'(r.op2);
            if (sum <= 64'hFFFF_FFFF) begin resp = 2'b01; data = DW'(sum); end
         end
         4'd2: if (r.op2 <= r.op1) begin resp = 2'b01; data = r.op1 - r.op2; end
         4'd5: if (SHIFT_EN) begin resp = 2'b01; data = r.op1 << r.op2[4:0]; end
         4'd6: if (SHIFT_EN) begin resp = 2'b01; data = r.op1 >> r.op2[4:0]; end
         default: ;
      endcase
   endfunction

   task automatic resetModel();
      for (int p = 0; p < N; p++) begin
         mq[p].delete();
         inOp2[p]   = 1'b0;
         expResp[p] = '0;
         expTag[p]  = '0;
         expData[p] = '0;
      end
      rr = 0;
   endtask

   // Advance the model by one clock edge using the inputs currently being driven.
   task automatic modelEdge();
      int   sizeBefore [N];
      int   g;
      req_t r;
      for (int p = 0; p < N; p++) begin
         expResp[p] = '0; expTag[p] = '0; expData[p] = '0;
         sizeBefore[p] = mq[p].size();
      end
      if (reset) begin resetModel(); return; end
      g = -1;
      for (int k = 0; k < N; k++) begin
         int idx = (rr + k) % N;
         if (g < 0 && mq[idx].size() > 0) g = idx;
      end
      if (g >= 0) begin
         r = mq[g].pop_front();
         calcExpected(r, expResp[g], expData[g]);
         expTag[g] = r.tag;
         rr = (g + 1) % N;
      end
      for (int p = 0; p < N; p++) begin
         if (inOp2[p]) begin
            r = cap[p];
            r.op2 = req_data_in[p*DW +: DW];
            mq[p].push_back(r);
            inOp2[p] = 1'b0;
         end else if (req_cmd_in[p*4 +: 4] != 4'd0) begin
            if (sizeBefore[p] < QD) begin
               cap[p].cmd = req_cmd_in[p*4 +: 4];
               cap[p].tag = req_tag_in[p*TW +: TW];
               cap[p].op1 = req_data_in[p*DW +: DW];
               cap[p].op2 = '0;
               inOp2[p]   = 1'b1;
            end else begin
               dropCount[p]++;
            end
         end
      end
   endtask

   task automatic compareAll(input string phase);
      for (int p = 0; p < N; p++) begin
         checkOutput($sformatf("%s p%0d resp", phase, p), 64'(resp_out[p*2 +: 2]), 64'(expResp[p]));
         checkOutput($sformatf("%s p%0d tag", phase, p), 64'(tag_out[p*TW +: TW]), 64'(expTag[p]));
         checkOutput($sformatf("%s p%0d data", phase, p), 64'(data_out[p*DW +: DW]), 64'(expData[p]));
         checkOutput($sformatf("%s p%0d busy", phase, p), 64'(req_busy[p]), 64'(mq[p].size() == QD));
      end
   endtask

   task automatic applyStimulus(input string phase);
      modelEdge();
      @(posedge c_clk);
      #1;
      compareAll(phase);
   endtask

   task automatic setIdle();
      req_cmd_in  = '0;
      req_tag_in  = '0;
      req_data_in = '0;
   endtask

   task automatic setPort(input int p, input logic [3:0] cmd, input logic [TW-1:0] tag,
                          input logic [DW-1:0] data);
      req_cmd_in[p*4 +: 4]   = cmd;
      req_tag_in[p*TW +: TW] = tag;
      req_data_in[p*DW +: DW] = data;
   endtask

   function automatic bit modelBusy();
      bit b = 1'b0;
      for (int p = 0; p < N; p++) if (mq[p].size() > 0 || inOp2[p]) b = 1'b1;
      return b;
   endfunction

   task automatic drain();
      int guard = 0;
      setIdle();
      while (modelBusy() && guard < 60) begin
         applyStimulus("drain");
         guard++;
      end
      checkOutput("drain complete", 64'(modelBusy()), 64'(0));
      applyStimulus("drain");
   endtask

   task automatic directedOp(input string name, input int p, input logic [3:0] cmd,
                             input logic [TW-1:0] tag, input logic [DW-1:0] op1,
                             input logic [DW-1:0] op2, input logic [1:0] wantResp,
                             input logic [DW-1:0] wantData);
      drain();
      setPort(p, cmd, tag, op1);
      applyStimulus(name);
      setPort(p, 4'hF, ~tag, op2);
      applyStimulus(name);
      setIdle();
      checkOutput({name, " no early resp"}, 64'(resp_out[p*2 +: 2]), 64'(0));
      applyStimulus(name);
      checkOutput({name, " resp"}, 64'(resp_out[p*2 +: 2]), 64'(wantResp));
      checkOutput({name, " tag"}, 64'(tag_out[p*TW +: TW]), 64'(tag));
      checkOutput({name, " data"}, 64'(data_out[p*DW +: DW]), 64'(wantData));
   endtask

   task automatic fairness(input string name, input int first);
      int order [$];
      int cyc [$];
      drain();
      for (int p = 0; p < N; p++) setPort(p, 4'd1, TW'(p), DW'(p * 100));
      applyStimulus(name);
      for (int p = 0; p < N; p++) setPort(p, 4'd0, '0, 32'd1);
      applyStimulus(name);
      setIdle();
      for (int c = 0; c < 8; c++) begin
         applyStimulus(name);
         for (int p = 0; p < N; p++) begin
            if (resp_out[p*2 +: 2] != 2'b00) begin order.push_back(p); cyc.push_back(c); end
         end
      end
      checkOutput({name, " resp count"}, 64'(order.size()), 64'(4));
      for (int i = 0; i < 4 && i < order.size(); i++) begin
         checkOutput($sformatf("%s order %0d", name, i), 64'(order[i]), 64'((first + i) % N));
         checkOutput($sformatf("%s cycle %0d", name, i), 64'(cyc[i]), 64'(i));
      end
   endtask

   function automatic logic [DW-1:0] randData();
      case ($urandom_range(0, 5))
         0:       return 32'hFFFF_FFFF;
         1:       return '0;
         2:       return DW'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [3:0] randCmd();
      case ($urandom_range(0, 9))
         0, 1, 2, 3: return 4'd0;
         4:          return 4'd1;
         5:          return 4'd2;
         6:          return 4'd5;
         7:          return 4'd6;
         default:    return 4'($urandom_range(1, 15));
      endcase
   endfunction

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit sawBusy;
      int stale;
      setIdle();
      resetModel();
      for (int p = 0; p < N; p++) dropCount[p] = 0;
      @(negedge c_clk);
      checkOutput("reset resp", 64'(resp_out), 64'(0));
      checkOutput("reset tag", 64'(tag_out), 64'(0));
      checkOutput("reset data nonzero", 64'(|data_out), 64'(0));
      checkOutput("reset busy", 64'(req_busy), 64'(0));
      @(posedge c_clk);
      #1;
      reset = 1'b0;

      fairness("fair rr0", 0);
      directedOp("move rr", 1, 4'd1, 2'd1, 32'd10, 32'd20, 2'b01, 32'd30);
      fairness("fair rr2", 2);

      directedOp("add p0", 0, 4'd1, 2'd2, 32'd5, 32'd7, 2'b01, 32'd12);
      directedOp("add ovf", 3, 4'd1, 2'd1, 32'hFFFF_FFFF, 32'd1, 2'b10, 32'd0);
      directedOp("sub udf", 0, 4'd2, 2'd3, 32'd3, 32'd4, 2'b10, 32'd0);
      directedOp("sub ok", 2, 4'd2, 2'd0, 32'd9, 32'd4, 2'b01, 32'd5);
      directedOp("cmd3", 1, 4'd3, 2'd2, 32'd8, 32'd8, 2'b10, 32'd0);
      directedOp("shl", 2, 4'd5, 2'd1, 32'h1, 32'd4,
                 SHIFT_EN ? 2'b01 : 2'b10, SHIFT_EN ? 32'h10 : 32'h0);
      directedOp("shr", 3, 4'd6, 2'd2, 32'h80, 32'd3,
                 SHIFT_EN ? 2'b01 : 2'b10, SHIFT_EN ? 32'h10 : 32'h0);

      // Every port issues back-to-back, so port 1 fills while competing for grants.
      drain();
      for (int p = 0; p < N; p++) dropCount[p] = 0;
      sawBusy = 1'b0;
      for (int c = 0; c < 48; c++) begin
         for (int p = 0; p < N; p++) setPort(p, 4'd1, TW'(c / 2), randData());
         applyStimulus("flood");
         if (req_busy[1]) sawBusy = 1'b1;
      end
      checkOutput("flood busy1 seen", 64'(sawBusy), 64'(1));
      checkOutput("flood p1 dropped", 64'(dropCount[1] > 0), 64'(1));
      drain();

      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < N; p++) setPort(p, randCmd(), TW'($urandom), randData());
         applyStimulus("random");
      end
      drain();

      // Reset with three requests queued and one response already on the way.
      for (int p = 0; p < N; p++) setPort(p, 4'd1, TW'(p), 32'd50);
      applyStimulus("rst setup");
      for (int p = 0; p < N; p++) setPort(p, 4'd0, '0, 32'd1);
      applyStimulus("rst setup");
      setIdle();
      applyStimulus("rst setup");
      #2;
      reset = 1'b1;
      resetModel();
      @(negedge c_clk);
      compareAll("rst mid");
      checkOutput("rst mid resp", 64'(resp_out), 64'(0));
      checkOutput("rst mid data nonzero", 64'(|data_out), 64'(0));
      applyStimulus("rst hold");
      reset = 1'b0;
      stale = 0;
      for (int c = 0; c < 10; c++) begin
         applyStimulus("post rst");
         if (resp_out != '0) stale++;
      end
      checkOutput("post rst stale", 64'(stale), 64'(0));

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
